// File: rtl/machine_timer.sv
// rtl/machine_timer.sv - memory-mapped RISC-V mtime/mtimecmp timer with prescaler and interrupt pulse
module machine_timer #(
  parameter int          DW      = 32,
  parameter int          PRESC_W = 8,
  parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cs,
  input  logic          we,
  input  logic [3:0]    mask,
  input  logic [2:0]    addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          t_intr
);
  localparam logic [2:0] A_MTIME_LO = 3'd0;
  localparam logic [2:0] A_MTIME_HI = 3'd1;
  localparam logic [2:0] A_CMP_LO   = 3'd2;
  localparam logic [2:0] A_CMP_HI   = 3'd3;
  localparam logic [2:0] A_CTRL     = 3'd4;
  localparam logic [2:0] A_STATUS   = 3'd5;

  logic [63:0]        mtime;
  logic [63:0]        mtimecmp;
  logic               en;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] pcnt;
  logic               pending;
  logic               match_q;

  logic               wr;
  logic               tick;
  logic               match;
  logic               fire;
  logic [DW-1:0]      bit_mask;
  logic [DW-1:0]      ctrl_word;
  logic               en_next;
  logic [PRESC_W-1:0] presc_next;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_val);
    return (old_val & ~bit_mask) | (wdata_i & bit_mask);
  endfunction

  always_comb begin
    wr       = cs && we;
    tick     = en && (pcnt == presc);
    match    = mtime >= mtimecmp;
    fire     = en && match && !match_q;
    bit_mask = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
  end

  always_comb begin
    ctrl_word              = '0;
    ctrl_word[0]           = en;
    ctrl_word[8 +: PRESC_W] = presc;
    en_next                = mask[0] ? wdata_i[0] : en;
    presc_next             = (presc & ~bit_mask[8 +: PRESC_W]) |
                             (wdata_i[8 +: PRESC_W] & bit_mask[8 +: PRESC_W]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime    <= '0;
      mtimecmp <= CMP_RST;
      en       <= 1'b0;
      presc    <= '0;
      pcnt     <= '0;
      pending  <= 1'b0;
      match_q  <= 1'b0;
      t_intr   <= 1'b0;
    end else begin
      if (wr && addr_i == A_CTRL) begin
        en    <= en_next;
        presc <= presc_next;
        pcnt  <= '0;
      end else if (en) begin
        pcnt <= tick ? '0 : pcnt + PRESC_W'(1);
      end

      // a bus write to either half wins over the tick; the other half keeps its pre-increment value
      if (wr && addr_i == A_MTIME_LO)
        mtime <= {mtime[63:32], merge(mtime[31:0])};
      else if (wr && addr_i == A_MTIME_HI)
        mtime <= {merge(mtime[63:32]), mtime[31:0]};
      else if (tick)
        mtime <= mtime + 64'd1;

      if (wr && addr_i == A_CMP_LO)
        mtimecmp[31:0] <= merge(mtimecmp[31:0]);
      if (wr && addr_i == A_CMP_HI)
        mtimecmp[63:32] <= merge(mtimecmp[63:32]);

      match_q <= en && match;
      t_intr  <= fire;

      if (fire)
        pending <= 1'b1;
      else if (wr && addr_i == A_STATUS && mask[0] && wdata_i[0])
        pending <= 1'b0;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (cs && !we) begin
      case (addr_i)
        A_MTIME_LO: rdata_o = mtime[31:0];
        A_MTIME_HI: rdata_o = mtime[63:32];
        A_CMP_LO:   rdata_o = mtimecmp[31:0];
        A_CMP_HI:   rdata_o = mtimecmp[63:32];
        A_CTRL:     rdata_o = ctrl_word;
        A_STATUS:   rdata_o = {{(DW-1){1'b0}}, pending};
        default:    rdata_o = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_machine_timer.sv
// tb/tb_machine_timer.sv - directed scoreboard bench for machine_timer
module tb_machine_timer;
  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        we;
  logic [3:0]  mask;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        t_intr;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] exp_q[$];

  machine_timer dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .cs     (cs),
    .we     (we),
    .mask   (mask),
    .addr_i (addr),
    .wdata_i(wdata),
    .rdata_o(rdata),
    .t_intr (t_intr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    e = exp_q.pop_front();
    n_checks++;
    assert (obs === e) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  task automatic read_exp(input logic [2:0] a, input logic [31:0] e, input string tag);
    exp_q.push_back(e);
    cs   = 1'b1;
    we   = 1'b0;
    addr = a;
    #1;
    check(tag, rdata);
    cs   = 1'b0;
  endtask

  task automatic intr_exp(input logic e, input string tag);
    exp_q.push_back({31'b0, e});
    #1;
    check(tag, {31'b0, t_intr});
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] m);
    cs    = 1'b1;
    we    = 1'b1;
    addr  = a;
    wdata = d;
    mask  = m;
    @(negedge clk);
    cs    = 1'b0;
    we    = 1'b0;
    mask  = 4'b0000;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_values(input string pfx);
    logic [31:0] rv [8];
    rv = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 8; i++) begin
      read_exp(3'(i), rv[i], $sformatf("%s_idx%0d", pfx, i));
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; cs = 1'b0; we = 1'b0; mask = 4'b0; addr = 3'd0; wdata = 32'h0;
    @(negedge clk);
    rst = 1'b0;

    // reset state, idle bus reads zero, no interrupt with en=1 and compare at all ones
    check_reset_values("t1_rst");
    exp_q.push_back(32'h0);
    addr = 3'd2;
    #1;
    check("t1_idle_rdata", rdata);
    @(negedge clk);
    bus_write(3'd4, 32'h0000_0001, 4'hF);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      intr_exp(1'b0, "t1_no_intr");
    end

    // presc 0 count to compare 10, then re-arm by toggling en
    do_reset();
    bus_write(3'd3, 32'h0, 4'hF);
    bus_write(3'd2, 32'd10, 4'hF);
    bus_write(3'd4, 32'h0000_0001, 4'hF);
    wait_cycles(10);
    read_exp(3'd0, 32'd10, "t2_mtime_lo");
    intr_exp(1'b0, "t2_intr_before");
    wait_cycles(1);
    intr_exp(1'b1, "t2_intr_pulse");
    read_exp(3'd5, 32'h1, "t2_status");
    wait_cycles(1);
    intr_exp(1'b0, "t2_intr_after");
    bus_write(3'd4, 32'h0000_0000, 4'hF);
    bus_write(3'd4, 32'h0000_0001, 4'hF);
    intr_exp(1'b0, "t2_rearm_en_edge");
    wait_cycles(1);
    intr_exp(1'b1, "t2_rearm_pulse");
    wait_cycles(1);
    intr_exp(1'b0, "t2_rearm_after");

    // presc 3: one increment per four cycles, en=0 holds
    do_reset();
    bus_write(3'd4, 32'h0000_0301, 4'hF);
    wait_cycles(39);
    read_exp(3'd0, 32'd9, "t3_mtime_39");
    wait_cycles(1);
    read_exp(3'd0, 32'd10, "t3_mtime_40");
    read_exp(3'd4, 32'h0000_0301, "t3_ctrl");
    bus_write(3'd4, 32'h0000_0300, 4'hF);
    wait_cycles(20);
    read_exp(3'd0, 32'd10, "t3_hold_lo");
    read_exp(3'd1, 32'd0, "t3_hold_hi");

    // wrap from all ones: pulse only when mtime reaches 5 again
    do_reset();
    bus_write(3'd3, 32'h0, 4'hF);
    bus_write(3'd2, 32'd5, 4'hF);
    bus_write(3'd4, 32'h0000_0001, 4'hF);
    wait_cycles(5);
    intr_exp(1'b0, "t4_pre5");
    wait_cycles(1);
    intr_exp(1'b1, "t4_first_pulse");
    wait_cycles(1);
    intr_exp(1'b0, "t4_first_after");
    bus_write(3'd0, 32'hFFFF_FFFF, 4'hF);
    bus_write(3'd1, 32'hFFFF_FFFF, 4'hF);
    read_exp(3'd0, 32'hFFFF_FFFF, "t4_ones_lo");
    read_exp(3'd1, 32'hFFFF_FFFF, "t4_ones_hi");
    intr_exp(1'b0, "t4_ones_intr");
    wait_cycles(1);
    read_exp(3'd0, 32'h0, "t4_wrap_lo");
    read_exp(3'd1, 32'h0, "t4_wrap_hi");
    for (int j = 1; j <= 5; j++) begin
      wait_cycles(1);
      intr_exp(1'b0, $sformatf("t4_no_intr_%0d", j));
    end
    wait_cycles(1);
    intr_exp(1'b1, "t4_pulse_at_5");
    wait_cycles(1);
    intr_exp(1'b0, "t4_pulse_end");

    // set wins over clear in the same cycle; clear needs mask[0]
    do_reset();
    bus_write(3'd3, 32'h0, 4'hF);
    bus_write(3'd2, 32'd10, 4'hF);
    bus_write(3'd4, 32'h0000_0001, 4'hF);
    wait_cycles(10);
    bus_write(3'd5, 32'h1, 4'b0001);
    intr_exp(1'b1, "t5_pulse");
    read_exp(3'd5, 32'h1, "t5_set_wins");
    bus_write(3'd5, 32'h1, 4'b1110);
    read_exp(3'd5, 32'h1, "t5_masked_clear");
    bus_write(3'd5, 32'h1, 4'b0001);
    read_exp(3'd5, 32'h0, "t5_cleared");

    // byte-lane write over reset compare value
    do_reset();
    bus_write(3'd2, 32'h0000_AB00, 4'b0010);
    read_exp(3'd2, 32'hFFFF_ABFF, "t6_byte_lo");
    read_exp(3'd3, 32'hFFFF_FFFF, "t6_byte_hi");

    // reset mid-count with pending set
    bus_write(3'd3, 32'h0, 4'hF);
    bus_write(3'd2, 32'd3, 4'hF);
    bus_write(3'd4, 32'h0000_0001, 4'hF);
    wait_cycles(8);
    read_exp(3'd5, 32'h1, "t6_pending_set");
    read_exp(3'd0, 32'd8, "t6_mtime_8");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    intr_exp(1'b0, "t6_rst_intr");
    check_reset_values("t6_rst");

    // reset on the edge that would raise the pulse drops it
    bus_write(3'd3, 32'h0, 4'hF);
    bus_write(3'd2, 32'd3, 4'hF);
    bus_write(3'd4, 32'h0000_0001, 4'hF);
    wait_cycles(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    intr_exp(1'b0, "t6_inflight_dropped");
    check_reset_values("t6_inflight");
    intr_exp(1'b0, "t6_no_late_pulse");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
